waverforms_mul_scale_pipe: RTL and testbench
============================================

// Module: waverforms_mul_scale_pipe
// PURPOSE
//   Pipelined unsigned x signed multiplier with valid/ready handshake, rounding right-shift and
//   output saturation. Scales signed waveform samples (din1) by an unsigned amplitude (din0).
//   Output is a fixed-point sample ready for the DAC path.
//   Sits between the waveform generators and the output mixer in the waverforms datapath.
// PARAMETERS
//   A_W       15  width of unsigned operand din0
//   B_W       15  width of signed operand din1
//   OUT_W     12  width of signed result dout
//   SHIFT     14  arithmetic right shift applied to product (range 0..A_W+B_W-1)
//   NUM_STAGE 3   pipeline depth = latency in cycles (minimum 2)
//   ROUND     1   1: round half up (add 2^(SHIFT-1) before shift); 0: truncate (floor)
//   SAT       1   1: saturate to OUT_W; 0: wrap (keep low OUT_W bits)
// PORTS
//   ap_clk     in   1      clock, all logic rising-edge
//   ap_rst     in   1      synchronous reset, active-high
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block accepts beat when in_valid && in_ready
//   din0       in   A_W    unsigned amplitude
//   din1       in   B_W    signed sample
//   in_last    in   1      frame marker, delayed alongside data
//   out_valid  out  1      dout/out_last valid
//   out_ready  in   1      downstream accepts when out_valid && out_ready
//   dout       out  OUT_W  scaled, rounded, saturated result (signed)
//   out_last   out  1      delayed in_last
//   sat_flag   out  1      sticky: a saturated (or wrapped) result left the pipe
//   sat_clr    in   1      clears sat_flag
// BEHAVIOUR
//   - Reset: all stage valid bits, out_valid, sat_flag = 0; dout = 0, out_last = 0.
//     Data registers need no reset. Reset mid-operation discards all in-flight beats.
//   - Product P = $signed({1'b0,din0}) * $signed(din1). Internal width PW = A_W+B_W+1 (guard bit for round add).
//   - R = (P + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, arithmetic shift.
//   - Saturation when SAT=1: R > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1; R < -2^(OUT_W-1) gives -2^(OUT_W-1).
//     A clamp or wrap counts as an overflow event.
//   - Pipeline:
//       stage 1 registers the operands;
//       stage 2 registers P;
//       stages 3..NUM_STAGE-1 delay P;
//       stage NUM_STAGE registers dout, out_last and the ovf bit.
//     When NUM_STAGE=2, P and round/sat are combined in stage 2.
//   - Stall-all flow control: advance = !out_valid || out_ready; in_ready = advance (combinational).
//     On advance every stage shifts one step, and bubbles shift too.
//     With no stall, latency = NUM_STAGE cycles from acceptance to out_valid.
//   - out_valid/dout/out_last hold stable while out_valid && !out_ready.
//   - No loss, no duplication, order preserved; throughput is 1 beat/cycle when out_ready=1.
//   - sat_flag is set in the cycle a beat with ovf=1 is transferred (out_valid && out_ready).
//     sat_clr clears it; if set and clear coincide, set wins.
//   - in_valid must not depend on in_ready. Inputs are ignored when not accepted.
// STRUCTURE
//   - waverforms_pkg holds:
//       function prod_w(A_W,B_W);
//       function sat_max(OUT_W) and sat_min(OUT_W);
//       localparam typedef for the stage record {valid, last, data}.
//   - One sub-module, waverforms_round_sat. It is purely combinational: P, SHIFT, ROUND, SAT -> dout, ovf.
//     It is instantiated in the final stage.
//   - Stage registers use a generate loop over NUM_STAGE.
// TESTING (defaults unless noted)
//   1. din0=16384, din1=-1000, out_ready=1 -> dout=-1000, ovf=0.
//      Appears exactly 3 cycles after acceptance.
//   2. Rounding:
//        din0=1, din1=8192 -> 1;  din0=1, din1=-8192 -> 0;  din0=1, din1=8191 -> 0.
//        With ROUND=0: din0=1, din1=-8192 -> -1.
//   3. Saturation: din0=16384, din1=3000 -> 2047, sat_flag=1; din1=-3000 -> -2048.
//      With SAT=0, din1=3000 -> 3000 mod 4096 as signed = -1096, and sat_flag=1.
//   4. Backpressure:
//        stimulus: stream 8 beats (din1=1..8, din0=16384, last on beat 8); hold out_ready=0 for 5 cycles mid-stream.
//        required: dout 1..8 in order, none lost; in_ready=0 while out_valid && !out_ready;
//                  out_last only on 8; dout held stable during the stall.
//   5. ap_rst asserted 1 cycle with 3 beats in flight -> next cycle out_valid=0, sat_flag=0.
//      No stale beat emerges afterwards.
//   6. sat_clr=1 in the same cycle a saturating beat transfers -> sat_flag=1.
//      sat_clr alone on the next cycle -> sat_flag=0.

Source files
------------

// File: rtl/waverforms_pkg.sv
// rtl/waverforms_pkg.sv - shared sizing helpers for the waverforms scaling pipe
package waverforms_pkg;

   // One guard bit above the full product keeps the rounding add from overflowing.
   function automatic int prod_w(input int a_w, input int b_w);
      return a_w + b_w + 1;
   endfunction

   function automatic longint sat_max(input int out_w);
      return (longint'(1) <<< (out_w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int out_w);
      return -(longint'(1) <<< (out_w - 1));
   endfunction

endpackage

// File: rtl/waverforms_round_sat.sv
// rtl/waverforms_round_sat.sv - combinational round, arithmetic shift and clamp/wrap of a product
module waverforms_round_sat
   import waverforms_pkg::*;
#(
   parameter int PW    = 31,
   parameter int OUT_W = 12,
   parameter int SHIFT = 14,
   parameter int ROUND = 1,
   parameter int SAT   = 1
) (
   input  logic signed [PW-1:0]    p,
   output logic signed [OUT_W-1:0] dout,
   output logic                    ovf
);

   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [PW-1:0] RND_ADD =
      (ROUND != 0 && SHIFT > 0) ? PW'(longint'(1) <<< RND_SH) : '0;
   localparam logic signed [PW-1:0] HI = PW'(sat_max(OUT_W));
   localparam logic signed [PW-1:0] LO = PW'(sat_min(OUT_W));

   logic signed [PW-1:0] r;

   always_comb begin
      r    = (p + RND_ADD) >>> SHIFT;
      ovf  = (r > HI) || (r < LO);
      dout = r[OUT_W-1:0];
      if (SAT != 0 && r > HI) begin
         dout = HI[OUT_W-1:0];
      end else if (SAT != 0 && r < LO) begin
         dout = LO[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/waverforms_mul_scale_pipe.sv
// rtl/waverforms_mul_scale_pipe.sv - stall-all pipelined unsigned x signed scaler with round/saturate
module waverforms_mul_scale_pipe
   import waverforms_pkg::*;
#(
   parameter int A_W       = 15,
   parameter int B_W       = 15,
   parameter int OUT_W     = 12,
   parameter int SHIFT     = 14,
   parameter int NUM_STAGE = 3,
   parameter int ROUND     = 1,
   parameter int SAT       = 1
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [A_W-1:0]          din0,
   input  logic [B_W-1:0]          din1,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] dout,
   output logic                    out_last,
   output logic                    sat_flag,
   input  logic                    sat_clr
);

   localparam int PW = prod_w(A_W, B_W);

   typedef struct packed {
      logic          valid;
      logic          last;
      logic [PW-1:0] data;
   } stage_t;

   stage_t s_d [1:NUM_STAGE-1];
   stage_t s_q [1:NUM_STAGE-1];

   logic                    advance;
   logic signed [PW-1:0]    prod;
   logic signed [PW-1:0]    fin_p;
   logic signed [OUT_W-1:0] fin_dout;
   logic                    fin_ovf;
   logic                    out_valid_d, out_valid_q;
   logic signed [OUT_W-1:0] dout_d, dout_q;
   logic                    out_last_d, out_last_q;
   logic                    ovf_d, ovf_q;
   logic                    sat_flag_d, sat_flag_q;

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   // Stage 1 holds {0,din0,din1}, exactly PW bits, so the zero-extended amplitude is the top field.
   always_comb begin
      prod   = PW'($signed(s_q[1].data[PW-1:B_W])) * PW'($signed(s_q[1].data[B_W-1:0]));
      s_d[1] = {in_valid, in_last, 1'b0, din0, din1};
      for (int k = 2; k < NUM_STAGE; k++) begin
         s_d[k] = s_q[k-1];
         if (k == 2) begin
            s_d[k].data = prod;
         end
      end
      fin_p = (NUM_STAGE == 2) ? prod : $signed(s_q[NUM_STAGE-1].data);
   end

   for (genvar g = 1; g < NUM_STAGE; g++) begin : g_stage
      always_ff @(posedge ap_clk) begin
         if (ap_rst) begin
            s_q[g].valid <= 1'b0;
         end else if (advance) begin
            s_q[g] <= s_d[g];
         end
      end
   end

   waverforms_round_sat #(
      .PW    (PW),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT),
      .ROUND (ROUND),
      .SAT   (SAT)
   ) u_round_sat (
      .p    (fin_p),
      .dout (fin_dout),
      .ovf  (fin_ovf)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      out_last_d  = out_last_q;
      ovf_d       = ovf_q;
      if (advance) begin
         out_valid_d = s_q[NUM_STAGE-1].valid;
         dout_d      = fin_dout;
         out_last_d  = s_q[NUM_STAGE-1].last;
         ovf_d       = fin_ovf;
      end
      // A transferring overflow beat beats a coincident clear.
      sat_flag_d = sat_flag_q;
      if (sat_clr) begin
         sat_flag_d = 1'b0;
      end
      if (out_valid_q && out_ready && ovf_q) begin
         sat_flag_d = 1'b1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         out_last_q  <= 1'b0;
         ovf_q       <= 1'b0;
         sat_flag_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         out_last_q  <= out_last_d;
         ovf_q       <= ovf_d;
         sat_flag_q  <= sat_flag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign out_last  = out_last_q;
   assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_waverforms_mul_scale_pipe.sv
// tb/tb_waverforms_mul_scale_pipe.sv - randomized scoreboard bench for the scaling pipe
module tb_waverforms_mul_scale_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        ap_rst, in_valid, in_last, out_ready, sat_clr;
   logic [14:0] din0, din1;
   logic        in_ready_a [3];
   logic        out_valid_a [3];
   logic        out_last_a [3];
   logic        sat_a [3];
   logic [11:0] dout_a [3];

   // Instance 0: defaults, 1: truncating, 2: wrapping.
   waverforms_mul_scale_pipe u_dut (
      .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_a[0]),
      .din0(din0), .din1(din1), .in_last(in_last), .out_valid(out_valid_a[0]),
      .out_ready(out_ready), .dout(dout_a[0]), .out_last(out_last_a[0]),
      .sat_flag(sat_a[0]), .sat_clr(sat_clr));

   waverforms_mul_scale_pipe #(.ROUND(0)) u_dut_r0 (
      .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_a[1]),
      .din0(din0), .din1(din1), .in_last(in_last), .out_valid(out_valid_a[1]),
      .out_ready(out_ready), .dout(dout_a[1]), .out_last(out_last_a[1]),
      .sat_flag(sat_a[1]), .sat_clr(sat_clr));

   waverforms_mul_scale_pipe #(.SAT(0)) u_dut_s0 (
      .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_a[2]),
      .din0(din0), .din1(din1), .in_last(in_last), .out_valid(out_valid_a[2]),
      .out_ready(out_ready), .dout(dout_a[2]), .out_last(out_last_a[2]),
      .sat_flag(sat_a[2]), .sat_clr(sat_clr));

   typedef struct {
      logic signed [11:0] d;
      logic               last;
      logic               ovf;
   } exp_t;

   exp_t        sb [3][$];
   int          errors = 0;
   int          checks = 0;
   logic        exp_sat [3];
   logic        stall_prev [3];
   logic [11:0] dout_prev [3];
   int          xfer_cnt = 0;
   int          stall_cnt = 0;
   logic        rand_mode = 1'b0;
   longint      res [3];
   int          lat;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Value-level reference: exact integer product, floor division, then clamp or modulo.
   function automatic exp_t model(input int a, input int b, input bit rnd, input bit sat,
                                  input logic last);
      exp_t   e;
      longint p, r, w;
      p = longint'(a) * longint'(b);
      if (rnd) p = p + 8192;
      r = p / 16384;
      if ((p % 16384) != 0 && p < 0) r = r - 1;
      e.ovf = (r > 2047) || (r < -2048);
      if (sat && r > 2047) w = 2047;
      else if (sat && r < -2048) w = -2048;
      else begin
         w = r % 4096;
         if (w < 0) w = w + 4096;
         if (w >= 2048) w = w - 4096;
      end
      e.d    = 12'(w);
      e.last = last;
      return e;
   endfunction

   always @(negedge clk) begin
      if (ap_rst) begin
         for (int i = 0; i < 3; i++) begin
            sb[i].delete();
            exp_sat[i]    = 1'b0;
            stall_prev[i] = 1'b0;
         end
      end else begin
         if (!in_ready_a[0]) stall_cnt++;
         for (int i = 0; i < 3; i++) begin
            exp_t e;
            logic setf;
            setf = 1'b0;
            chk($sformatf("sat_flag[%0d]", i), sat_a[i], exp_sat[i]);
            chk($sformatf("in_ready[%0d]", i), in_ready_a[i], !(out_valid_a[i] && !out_ready));
            if (stall_prev[i]) begin
               chk($sformatf("hold_valid[%0d]", i), out_valid_a[i], 1);
               chk($sformatf("hold_dout[%0d]", i), $signed(dout_a[i]), $signed(dout_prev[i]));
            end
            if (out_valid_a[i] && out_ready) begin
               if (sb[i].size() == 0) begin
                  chk($sformatf("unexpected_beat[%0d]", i), 1, 0);
               end else begin
                  e = sb[i].pop_front();
                  chk($sformatf("dout[%0d]", i), $signed(dout_a[i]), e.d);
                  chk($sformatf("out_last[%0d]", i), out_last_a[i], e.last);
                  setf = e.ovf;
                  if (i == 0) xfer_cnt++;
               end
            end
            stall_prev[i] = out_valid_a[i] && !out_ready;
            dout_prev[i]  = dout_a[i];
            if (in_valid && in_ready_a[i]) begin
               sb[i].push_back(model(int'(din0), int'($signed(din1)), i != 1, i != 2, in_last));
            end
            exp_sat[i] = setf ? 1'b1 : (sat_clr ? 1'b0 : exp_sat[i]);
         end
      end
   end

   always @(posedge clk) begin
      if (rand_mode) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
         sat_clr   = ($urandom_range(0, 7) == 0);
      end
   end

   task automatic send(input int a, input int b, input logic last);
      int   n;
      logic acc;
      in_valid = 1'b1;
      din0     = 15'(a);
      din1     = 15'(b);
      in_last  = last;
      n        = 0;
      forever begin
         @(negedge clk);
         acc = in_ready_a[0];
         @(posedge clk);
         #1;
         n++;
         if (acc) break;
         if (n >= 200) begin
            chk("accept_timeout", 1, 0);
            break;
         end
      end
   endtask

   task automatic run_one(input int a, input int b);
      int n;
      send(a, b, 1'b0);
      in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid_a[0] && n < 20);
      lat = n;
      for (int i = 0; i < 3; i++) res[i] = $signed(dout_a[i]);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (n >= 500) chk("drain_timeout", 1, 0);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t m;
      int   x0, s0, stale;
      ap_rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      sat_clr = 1'b0; din0 = '0; din1 = '0;
      repeat (3) @(posedge clk);
      #1 ap_rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_valid[%0d]", i), out_valid_a[i], 0);
         chk($sformatf("rst_dout[%0d]", i), dout_a[i], 0);
         chk($sformatf("rst_last[%0d]", i), out_last_a[i], 0);
         chk($sformatf("rst_sat[%0d]", i), sat_a[i], 0);
      end

      m = model(16384, -1000, 1, 1, 0); chk("model_basic", m.d, -1000);
      m = model(1, -8192, 0, 1, 0);     chk("model_trunc", m.d, -1);
      m = model(16384, 3000, 1, 0, 0);  chk("model_wrap", m.d, -1096);
      m = model(16384, 3000, 1, 1, 0);  chk("model_clamp_ovf", m.ovf, 1);

      @(posedge clk); #1;
      run_one(16384, -1000);
      chk("t1_latency", lat, 3);
      chk("t1_dout", res[0], -1000);
      run_one(1, 8192);  chk("t2_round_up", res[0], 1);
      run_one(1, -8192); chk("t2_round_neg", res[0], 0); chk("t2_trunc_neg", res[1], -1);
      run_one(1, 8191);  chk("t2_round_down", res[0], 0);
      chk("t2_no_sat", sat_a[0], 0);
      run_one(16384, 3000);
      chk("t3_clamp_hi", res[0], 2047);
      chk("t3_wrap", res[2], -1096);
      chk("t3_sat_flag", sat_a[0], 1);
      chk("t3_wrap_flag", sat_a[2], 1);
      run_one(16384, -3000);
      chk("t3_clamp_lo", res[0], -2048);

      x0 = xfer_cnt;
      s0 = stall_cnt;
      fork
         begin
            for (int k = 1; k <= 8; k++) send(16384, k, k == 8);
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("t4_beats", xfer_cnt - x0, 8);
      chk("t4_stall_cycles", stall_cnt - s0, 5);

      for (int k = 0; k < 3; k++) send(16384, 100 + k, 1'b0);
      in_valid = 1'b0;
      ap_rst   = 1'b1;
      @(posedge clk);
      #1 ap_rst = 1'b0;
      chk("t5_valid", out_valid_a[0], 0);
      chk("t5_sat", sat_a[0], 0);
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid_a[0]) stale++;
      end
      chk("t5_stale", stale, 0);
      @(posedge clk); #1;

      send(16384, 3000, 1'b0);
      in_valid = 1'b0;
      begin
         int n;
         n = 0;
         while (!out_valid_a[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         chk("t6_arrive", out_valid_a[0], 1);
      end
      sat_clr = 1'b1;
      @(posedge clk); #1;
      chk("t6_set_wins", sat_a[0], 1);
      @(posedge clk); #1;
      sat_clr = 1'b0;
      chk("t6_clear", sat_a[0], 0);

      rand_mode = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         send(int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)),
              $urandom_range(0, 7) == 0);
      end
      in_valid = 1'b0;
      drain();
      rand_mode = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      sat_clr   = 1'b0;
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
